// File: rtl/tmds_decoder_if.sv
// TMDS channel bundle: raw 10-bit symbol in, decoded pixel/control out.
// TMDS_DECODER_STATS_EN adds the slip_count statistic.
interface tmds_decoder_if;
   logic [9:0] din;
   logic [7:0] dout;
   logic [1:0] ctrl;
   logic       de;
   logic       bitslip;
   logic       locked;
`ifdef TMDS_DECODER_STATS_EN
   logic [7:0] slip_count;

   modport master (
      output din,
      input  dout, ctrl, de, bitslip, locked, slip_count
   );
   modport slave (
      input  din,
      output dout, ctrl, de, bitslip, locked, slip_count
   );
`else
   modport master (
      output din,
      input  dout, ctrl, de, bitslip, locked
   );
   modport slave (
      input  din,
      output dout, ctrl, de, bitslip, locked
   );
`endif
endinterface

// File: rtl/tmds_decoder.sv
// TMDS channel decoder: 2-stage symbol decode plus word-alignment/lock FSM.
// Optional TMDS_DECODER_STATS_EN adds a saturating bitslip counter.
module tmds_decoder #(
   parameter int CTRL_RUN     = 12,
   parameter int SEARCH_WIN   = 2048,
   parameter int SLIP_SETTLE  = 4,
   parameter int LOSS_TIMEOUT = 4096
) (
   input  logic          clk,
   input  logic          rst,
   tmds_decoder_if.slave bus
);
   localparam int RW = $clog2(CTRL_RUN + 1);
   localparam int CMAX = (SEARCH_WIN > SLIP_SETTLE) ? SEARCH_WIN : SLIP_SETTLE;
   localparam int CW = $clog2(CMAX + 1);
   localparam int TW = $clog2(LOSS_TIMEOUT + 1);

   localparam logic [9:0] C00 = 10'b1101010100;
   localparam logic [9:0] C01 = 10'b0010101011;
   localparam logic [9:0] C10 = 10'b0101010100;
   localparam logic [9:0] C11 = 10'b1010101011;

   typedef enum logic [1:0] {SEARCH, SLIP_WAIT, LOCKED} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [TW-1:0] tcnt, tcnt_nx;
   logic [RW-1:0] run, run_nx;
   logic          slip_nx;
   logic          slip_q, locked_q;

   logic [9:0] sym;
   logic       is_ctrl;
   logic [1:0] tok;
   logic [7:0] q, dec;
   logic [7:0] dout_q;
   logic [1:0] ctrl_q;
   logic       de_q;

   always_comb begin
      is_ctrl = 1'b1;
      tok     = 2'b00;
      unique case (1'b1)
         (sym == C00): tok = 2'b00;
         (sym == C01): tok = 2'b01;
         (sym == C10): tok = 2'b10;
         (sym == C11): tok = 2'b11;
         default:      is_ctrl = 1'b0;
      endcase
   end

   // Undo the optional inversion, then the XOR/XNOR transition chain.
   always_comb begin
      q   = sym[9] ? ~sym[7:0] : sym[7:0];
      dec = {q[7:1] ^ q[6:0] ^ {7{~sym[8]}}, q[0]};
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      tcnt_nx  = tcnt;
      slip_nx  = 1'b0;
      if (!is_ctrl)
         run_nx = '0;
      else if (run == RW'(CTRL_RUN))
         run_nx = run;
      else
         run_nx = run + RW'(1);
      unique case (state)
         SEARCH: begin
            if (run == RW'(CTRL_RUN)) begin
               state_nx = LOCKED;
               cnt_nx   = '0;
               tcnt_nx  = '0;
            end else if (cnt == CW'(SEARCH_WIN - 1)) begin
               state_nx = SLIP_WAIT;
               cnt_nx   = '0;
               slip_nx  = 1'b1;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         SLIP_WAIT: begin
            run_nx = '0;
            if (cnt == CW'(SLIP_SETTLE - 1)) begin
               state_nx = SEARCH;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         LOCKED: begin
            if (run == RW'(CTRL_RUN)) begin
               tcnt_nx = '0;
            end else if (tcnt == TW'(LOSS_TIMEOUT - 1)) begin
               state_nx = SEARCH;
               cnt_nx   = '0;
               tcnt_nx  = '0;
               run_nx   = '0;
            end else begin
               tcnt_nx = tcnt + TW'(1);
            end
         end
         default: state_nx = SEARCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= SEARCH;
         cnt      <= '0;
         tcnt     <= '0;
         run      <= '0;
         slip_q   <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         tcnt     <= tcnt_nx;
         run      <= run_nx;
         slip_q   <= slip_nx;
         locked_q <= (state_nx == LOCKED);
      end
   end

   // Outputs are gated by the lock state being entered on this edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sym    <= '0;
         dout_q <= '0;
         ctrl_q <= '0;
         de_q   <= 1'b0;
      end else begin
         sym <= bus.din;
         if (state_nx != LOCKED) begin
            dout_q <= '0;
            ctrl_q <= '0;
            de_q   <= 1'b0;
         end else if (is_ctrl) begin
            dout_q <= '0;
            ctrl_q <= tok;
            de_q   <= 1'b0;
         end else begin
            dout_q <= dec;
            de_q   <= 1'b1;
         end
      end
   end

   assign bus.dout    = dout_q;
   assign bus.ctrl    = ctrl_q;
   assign bus.de      = de_q;
   assign bus.bitslip = slip_q;
   assign bus.locked  = locked_q;

`ifdef TMDS_DECODER_STATS_EN
   logic [7:0] slip_cnt;

   always_ff @(posedge clk) begin
      if (rst)
         slip_cnt <= '0;
      else if (slip_nx && slip_cnt != 8'hFF)
         slip_cnt <= slip_cnt + 8'd1;
   end

   assign bus.slip_count = slip_cnt;
`endif
endmodule

// File: doc/tmds_decoder.md
TMDS_DECODER -- requirements
Module: tmds_decoder

Interface
REQ-001 SHALL have parameter CTRL_RUN, default 12: consecutive control tokens needed to declare lock.
REQ-002 SHALL have parameter SEARCH_WIN, default 2048: cycles in SEARCH before a bitslip request.
REQ-003 SHALL have parameter SLIP_SETTLE, default 4: cycles waited after bitslip before searching again.
REQ-004 SHALL have parameter LOSS_TIMEOUT, default 4096: cycles in LOCKED without a qualifying control run before lock is dropped.
REQ-005 SHALL have port clk, input, 1: pixel clock; the only clock.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port din, input, 10: raw deserialized TMDS symbol, one per clk, bit 0 first on the wire.
REQ-008 SHALL have port dout, output, 8: decoded pixel byte.
REQ-009 SHALL have port ctrl, output, 2: decoded control bits {C1,C0}.
REQ-010 SHALL have port de, output, 1: high when dout carries a data symbol.
REQ-011 SHALL have port bitslip, output, 1: single-cycle pulse asking the deserializer to shift word alignment by one bit.
REQ-012 SHALL have port locked, output, 1: high in state LOCKED.

Function
REQ-013 Stage 1 SHALL register din, then classify it: 1101010100->ctrl 00, 0010101011->01, 0101010100->10, 1010101011->11; any other value is data.
REQ-014 Data decode SHALL be: q = din[9] ? ~din[7:0] : din[7:0]; out[0]=q[0]; out[i]=q[i]^q[i-1] when din[8]=1, else ~(q[i]^q[i-1]), for i=1..7.
REQ-015 Stage 2 SHALL register dout/ctrl/de; latency din->outputs is exactly 2 clk.
REQ-016 Control symbol: de=0, ctrl=token value, dout=0. Data symbol: de=1, dout=decoded, ctrl holds its last control value.
REQ-017 While locked=0, stage-2 outputs SHALL be forced to de=0, ctrl=00, dout=0.
REQ-018 run counter SHALL count consecutive stage-1 control tokens, clear on any data symbol, and saturate at CTRL_RUN.
REQ-019 FSM states SHALL be SEARCH, SLIP_WAIT, LOCKED.
REQ-020 SEARCH: cycle counter increments; run==CTRL_RUN -> LOCKED; counter reaches SEARCH_WIN-1 -> pulse bitslip, go to SLIP_WAIT.
REQ-021 If run reaches CTRL_RUN in the cycle the window expires, LOCKED SHALL win and no bitslip SHALL be issued.
REQ-022 SLIP_WAIT: after exactly SLIP_SETTLE cycles, return to SEARCH with cycle and run counters cleared; symbols in this state SHALL NOT advance run.
REQ-023 LOCKED: timeout counter clears each cycle run==CTRL_RUN and otherwise increments; reaching LOSS_TIMEOUT-1 -> SEARCH, counters cleared.
REQ-024 bitslip SHALL be high for exactly one cycle per SEARCH->SLIP_WAIT transition and never in LOCKED.
REQ-025 locked SHALL be registered and change on the same edge as the FSM state.

Reset
REQ-026 On rst=1 at a clk edge: state=SEARCH; all counters=0; dout=0, ctrl=00, de=0, bitslip=0, locked=0; pipeline registers=0.
REQ-027 Reset asserted mid-operation, including during SLIP_WAIT or a bitslip pulse, SHALL take effect on that edge with no pending pulse afterwards.

Configuration
REQ-028 With macro TMDS_DECODER_STATS_EN defined, the block SHALL add output slip_count, 8 bits, counting bitslip pulses, saturating at 255, cleared by rst only.
REQ-029 Without TMDS_DECODER_STATS_EN, the port and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-030 Aligned stream of 20 x 1101010100 then data -> locked=1 on cycle 13 after the first token; de=0 with ctrl=00 during tokens.
REQ-031 Encoder-produced data for bytes 0x00, 0xFF, 0x55, 0xA7 after lock -> dout equals the same bytes 2 cycles later, de=1.
REQ-032 Stream rotated by 3 bits, with a model deserializer honouring bitslip -> exactly 3 bitslip pulses, each 2048 cycles apart plus settle, then locked=1.
REQ-033 Locked, then continuous data for 4096 cycles -> locked drops to 0 on cycle 4096; outputs forced to de=0, dout=0.
REQ-034 rst pulsed for 1 cycle in SLIP_WAIT -> all outputs 0 next cycle; the next bitslip comes only after a full 2048-cycle window.
REQ-035 With TMDS_DECODER_STATS_EN, force 300 slips -> slip_count saturates at 255; rst clears it to 0.
